// File: rtl/pu_pipe_if.sv
// Handshake bundle for one pu_pipe: input beat channel (x/w vectors) and result channel.
// The slave modport is the PU itself; the master modport is whoever feeds and drains it.
interface pu_pipe_if #(
   parameter int N      = 4,
   parameter int DATA_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [N*DATA_W-1:0]   x_flat;
   logic [N*DATA_W-1:0]   w_flat;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;

   modport master (
      output in_valid, in_last, x_flat, w_flat, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_last, x_flat, w_flat, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pu_pipe.sv
// Pipelined dot-product PU: input regs, multiplier stage, log2(N)-level adder tree,
// saturating accumulator, then ReLU/shift/saturate into a single-entry output register.
module pu_pipe #(
   parameter int N        = 4,
   parameter int DATA_W   = 5,
   parameter int ACC_W    = 16,
   parameter int SHIFT    = 0,
   parameter int ACT_RELU = 1
) (
   input logic      clk,
   input logic      rst,
   pu_pipe_if.slave bus
);
   localparam int L  = $clog2(N);
   localparam int PW = 2 * DATA_W;
   localparam int TW = PW + L;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

   // Valid/last per stage: [0] input regs, [1] products, [2..L+1] tree levels 1..L.
   logic [L+1:0]             r_v;
   logic [L+1:0]             r_l;
   logic [N*DATA_W-1:0]      r_x;
   logic [N*DATA_W-1:0]      r_w;
   // Tree level 0 holds the products; level k uses entries 0..(N>>k)-1, all at the final width.
   logic signed [TW-1:0]     r_tree [L+1][N];
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_out_valid;
   logic [DATA_W-1:0]        r_out_data;

   logic                     w_en;
   logic signed [PW-1:0]     w_prod [N];
   logic signed [ACC_W:0]    w_sum_wide;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic signed [ACC_W-1:0]  w_act;
   logic signed [ACC_W-1:0]  w_shr;
   logic [DATA_W-1:0]        w_res;

   assign w_en          = !r_out_valid || bus.out_ready;
   assign bus.in_ready  = w_en;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_prod[i] = PW'($signed(r_x[i*DATA_W +: DATA_W])) * PW'($signed(r_w[i*DATA_W +: DATA_W]));
      end
   end

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      w_sum_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_tree[L][0]);
      if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
         w_acc_next = w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         w_acc_next = w_sum_wide[ACC_W-1:0];
      end

      w_act = ((ACT_RELU != 0) && (w_acc_next < 0)) ? '0 : w_acc_next;
      w_shr = w_act >>> SHIFT;
      if (w_shr > OUT_MAX) begin
         w_res = OUT_MAX[DATA_W-1:0];
      end else if (w_shr < OUT_MIN) begin
         w_res = OUT_MIN[DATA_W-1:0];
      end else begin
         w_res = w_shr[DATA_W-1:0];
      end
   end

   // NOTE: all state uses <= so each stage takes its neighbour's pre-edge value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v         <= '0;
         r_l         <= '0;
         // NOTE: data registers are cleared along with valid bits so acc and out_data restart at 0.
         r_x         <= '0;
         r_w         <= '0;
         for (int k = 0; k <= L; k++) begin
            for (int i = 0; i < N; i++) begin
               r_tree[k][i] <= '0;
            end
         end
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_en) begin
         r_v <= {r_v[L:0], bus.in_valid};
         r_l <= {r_l[L:0], bus.in_last};
         r_x <= bus.x_flat;
         r_w <= bus.w_flat;
         for (int i = 0; i < N; i++) begin
            r_tree[0][i] <= TW'(w_prod[i]);
         end
         for (int k = 1; k <= L; k++) begin
            for (int i = 0; i < (N >> k); i++) begin
               r_tree[k][i] <= r_tree[k-1][2*i] + r_tree[k-1][2*i+1];
            end
         end

         // With en high the current output (if any) is being taken, so valid follows the new load.
         r_out_valid <= r_v[L+1] && r_l[L+1];
         if (r_v[L+1]) begin
            if (r_l[L+1]) begin
               r_acc      <= '0;
               r_out_data <= w_res;
            end else begin
               r_acc      <= w_acc_next;
            end
         end
      end
   end
endmodule

// File: tb/tb_pu_pipe.sv
// Directed bench for pu_pipe: a ReLU instance and an identity instance share one stimulus stream.
module tb_pu_pipe;
   localparam int N      = 4;
   localparam int DATA_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pu_pipe_if #(.N(N), .DATA_W(DATA_W)) bus ();
   pu_pipe_if #(.N(N), .DATA_W(DATA_W)) bus_id ();

   assign bus_id.in_valid  = bus.in_valid;
   assign bus_id.in_last   = bus.in_last;
   assign bus_id.x_flat    = bus.x_flat;
   assign bus_id.w_flat    = bus.w_flat;
   assign bus_id.out_ready = bus.out_ready;

   pu_pipe #(.N(N), .DATA_W(DATA_W), .ACC_W(16), .SHIFT(0), .ACT_RELU(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pu_pipe #(.N(N), .DATA_W(DATA_W), .ACC_W(16), .SHIFT(0), .ACT_RELU(0)) u_dut_id (
      .clk (clk),
      .rst (rst),
      .bus (bus_id)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sdata(input logic [DATA_W-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic drive(input int x0, input int x1, input int x2, input int x3,
                        input int w0, input int w1, input int w2, input int w3,
                        input bit last);
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      bus.x_flat   = {DATA_W'(x3), DATA_W'(x2), DATA_W'(x1), DATA_W'(x0)};
      bus.w_flat   = {DATA_W'(w3), DATA_W'(w2), DATA_W'(w1), DATA_W'(w0)};
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Waits (bounded) for a result, checks both instances, then lets it transfer.
   task automatic wait_out(input string tag, input int exp_relu, input int exp_id);
      int i = 0;
      while (!bus.out_valid && i < 20) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_valid"}, int'(bus.out_valid), 1);
      if (bus.out_valid) begin
         check({tag, "_relu"}, sdata(bus.out_data), exp_relu);
         check({tag, "_id"}, sdata(bus_id.out_data), exp_id);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  sent;
      int  got;
      int  hold;
      bit  seen;
      bit  pend;

      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.x_flat    = '0;
      bus.w_flat    = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", sdata(bus.out_data), 0);
      rst = 1'b1;
      #1;
      check("rst_in_ready", int'(bus.in_ready), 1);
      @(negedge clk);

      // Single beat: 1+2+3+4 = 10, visible after the 4th edge following acceptance
      drive(1, 2, 3, 4, 1, 1, 1, 1, 1'b1);
      idle();
      repeat (3) @(negedge clk);
      check("lat_early", int'(bus.out_valid), 0);
      @(negedge clk);
      check("lat_valid", int'(bus.out_valid), 1);
      check("lat_relu", sdata(bus.out_data), 10);
      check("lat_id", sdata(bus_id.out_data), 10);
      @(negedge clk);
      check("lat_cleared", int'(bus.out_valid), 0);

      // Activation: sum -24 -> ReLU 0, identity saturates to -16
      drive(-3, -3, -3, -3, 2, 2, 2, 2, 1'b1);
      idle();
      wait_out("act", 0, -16);

      // Multi-beat 4+4+4 = 12, then a fresh vector of 5 right behind it
      drive(1, 1, 1, 1, 1, 1, 1, 1, 1'b0);
      drive(1, 1, 1, 1, 1, 1, 1, 1, 1'b0);
      drive(1, 1, 1, 1, 1, 1, 1, 1, 1'b1);
      drive(1, 1, 1, 2, 1, 1, 1, 1, 1'b1);
      idle();
      wait_out("multi", 12, 12);
      wait_out("multi_next", 5, 5);

      // Backpressure: six single-beat vectors, sums 1..6, consumer stalls 5 cycles on the first result
      sent = 0;
      got  = 0;
      hold = 0;
      seen = 1'b0;
      pend = 1'b0;
      for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
         if (pend) sent++;
         if (bus.out_valid && !seen) begin
            seen = 1'b1;
            hold = 5;
         end
         if (hold > 0) begin
            bus.out_ready = 1'b0;
            hold--;
         end else begin
            bus.out_ready = 1'b1;
         end
         if (sent < 6) begin
            bus.in_valid = 1'b1;
            bus.in_last  = 1'b1;
            bus.x_flat   = (N*DATA_W)'(sent + 1);
            bus.w_flat   = {N{DATA_W'(1)}};
         end else begin
            idle();
         end
         #1;
         if (bus.out_valid && !bus.out_ready) begin
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_hold_data", sdata(bus.out_data), 1);
         end
         if (bus.out_valid && bus.out_ready) begin
            check("bp_order", sdata(bus.out_data), got + 1);
            got++;
         end
         pend = bus.in_valid && bus.in_ready;
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      idle();
      check("bp_count", got, 6);
      repeat (3) @(negedge clk);
      check("bp_drained", int'(bus.out_valid), 0);

      // Reset mid-vector: partial sum of 16 must be discarded
      drive(7, 0, 0, 0, 1, 1, 1, 1, 1'b1);
      drive(2, 2, 2, 2, 1, 1, 1, 1, 1'b0);
      drive(2, 2, 2, 2, 1, 1, 1, 1, 1'b0);
      idle();
      wait_out("rst_prev", 7, 7);
      repeat (2) @(negedge clk);
      check("rst_acc_before", int'(u_dut.r_acc), 16);
      rst = 1'b0;
      #1;
      check("rst_mid_valid", int'(bus.out_valid), 0);
      check("rst_mid_data", sdata(bus.out_data), 0);
      check("rst_mid_acc", int'(u_dut.r_acc), 0);
      @(negedge clk);
      rst = 1'b1;
      drive(3, 0, 0, 0, 1, 1, 1, 1, 1'b1);
      idle();
      wait_out("rst_after", 3, 3);

      // Accumulator saturation: 40 x 1024 clamps at 32767, output clamps at 15
      for (int i = 0; i < 40; i++) begin
         drive(-16, -16, -16, -16, -16, -16, -16, -16, 1'b0);
      end
      idle();
      repeat (6) @(negedge clk);
      check("sat_acc", int'(u_dut.r_acc), 32767);
      drive(-16, -16, -16, -16, -16, -16, -16, -16, 1'b1);
      idle();
      wait_out("sat", 15, 15);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
